// File: rtl/alu_pkg.sv
// Shared constants, opcodes and issue-FSM state type for the ALU front end.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_SEL_W  = 4;
    localparam int unsigned ALU_RES_W  = 9;

    localparam logic [ALU_SEL_W-1:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_AND  = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_OR   = 4'b0011;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_SHL  = 4'b0101;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_SHR  = 4'b0110;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_PASS = 4'b0111;

    typedef enum logic {
        IDLE,
        WAIT
    } issue_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with a 9-bit result; bit 8 carries carry/borrow/shift-out.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] i_a,
    input  logic [ALU_DATA_W-1:0] i_b,
    input  logic [ALU_SEL_W-1:0]  i_sel,
    output logic [ALU_RES_W-1:0]  o_result
);

    // Opcode decode; unassigned codes produce zero.
    always_comb begin
        o_result = '0;
        case (i_sel)
            ALU_OP_ADD:  o_result = {1'b0, i_a} + {1'b0, i_b};
            ALU_OP_SUB:  o_result = {1'b0, i_a} - {1'b0, i_b};
            ALU_OP_AND:  o_result = {1'b0, i_a & i_b};
            ALU_OP_OR:   o_result = {1'b0, i_a | i_b};
            ALU_OP_XOR:  o_result = {1'b0, i_a ^ i_b};
            ALU_OP_SHL:  o_result = {i_a, 1'b0};
            ALU_OP_SHR:  o_result = {2'b00, i_a[ALU_DATA_W-1:1]};
            ALU_OP_PASS: o_result = {1'b0, i_a};
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Response FIFO: wrap-bit pointers, count derived from pointer difference,
// head shown combinationally from storage.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_push_en;
    logic             w_pop_en;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_valid   = (w_count != '0);
    assign o_full    = (w_count == PTR_FULL);
    assign w_pop_en  = i_pop && o_valid;
    // A push into a full FIFO is still fine when the head leaves on the same edge.
    assign w_push_en = i_push && (!o_full || w_pop_en);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Sequential front end for the ALU: registers operands, waits SETTLE cycles,
// captures result plus tag into a response FIFO.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ALU_DATA_W-1:0] req_a,
    input  logic [ALU_DATA_W-1:0] req_b,
    input  logic [ALU_SEL_W-1:0]  req_sel,
    input  logic [TAG_W-1:0]      req_tag,
    output logic [ALU_DATA_W-1:0] alu_a,
    output logic [ALU_DATA_W-1:0] alu_b,
    output logic [ALU_SEL_W-1:0]  alu_sel,
    input  logic [ALU_RES_W-1:0]  alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ALU_RES_W-1:0]  rsp_result,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam int unsigned ENT_W = ALU_RES_W + TAG_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    issue_state_t          r_state;
    issue_state_t          w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [ALU_DATA_W-1:0] r_alu_a;
    logic [ALU_DATA_W-1:0] r_alu_b;
    logic [ALU_SEL_W-1:0]  r_alu_sel;
    logic [TAG_W-1:0]      r_tag;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic [ENT_W-1:0]      w_head;

    // Next state, settle countdown, handshake and capture strobe.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !w_fifo_full;
                if (req_valid && !w_fifo_full) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_capture    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and countdown registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Operand and tag registers; held through WAIT and kept in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_tag     <= '0;
        end else if (w_accept) begin
            r_alu_a   <= req_a;
            r_alu_b   <= req_b;
            r_alu_sel <= req_sel;
            r_tag     <= req_tag;
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_sel = r_alu_sel;
    assign busy    = (r_state == WAIT);
    assign w_pop   = rsp_valid && rsp_ready;

    alu_result_fifo #(
        .WIDTH(ENT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_data  ({alu_result, r_tag}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (rsp_valid),
        .o_full  (w_fifo_full)
    );

    assign rsp_result = w_head[ENT_W-1:TAG_W];
    assign rsp_tag    = w_head[TAG_W-1:0];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: two instances (SETTLE=1 and SETTLE=3, DEPTH=4),
// each driving a real alu, with a per-instance scoreboard fed on acceptance.
module tb_alu_issue_unit;

    logic clk;
    logic rst;

    logic       req_valid  [2];
    logic       req_ready  [2];
    logic [7:0] req_a      [2];
    logic [7:0] req_b      [2];
    logic [3:0] req_sel    [2];
    logic [3:0] req_tag    [2];
    logic [7:0] alu_a      [2];
    logic [7:0] alu_b      [2];
    logic [3:0] alu_sel    [2];
    logic [8:0] alu_result [2];
    logic       rsp_valid  [2];
    logic       rsp_ready  [2];
    logic [8:0] rsp_result [2];
    logic [3:0] rsp_tag    [2];
    logic       busy       [2];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU behaviour from plain integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] sel);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        case (sel)
            4'd0:    r = ia + ib;
            4'd1:    r = ia - ib + 512;
            4'd2:    r = ia & ib;
            4'd3:    r = ia | ib;
            4'd4:    r = ia ^ ib;
            4'd5:    r = ia * 2;
            4'd6:    r = ia / 2;
            4'd7:    r = ia;
            default: r = 0;
        endcase
        return 9'(r % 512);
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        logic [12:0] exp_q [$];

        alu u_alu (
            .i_a      (alu_a[i]),
            .i_b      (alu_b[i]),
            .i_sel    (alu_sel[i]),
            .o_result (alu_result[i])
        );

        alu_issue_unit #(
            .SETTLE((i == 0) ? 1 : 3),
            .DEPTH (4),
            .TAG_W (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[i]),
            .req_ready  (req_ready[i]),
            .req_a      (req_a[i]),
            .req_b      (req_b[i]),
            .req_sel    (req_sel[i]),
            .req_tag    (req_tag[i]),
            .alu_a      (alu_a[i]),
            .alu_b      (alu_b[i]),
            .alu_sel    (alu_sel[i]),
            .alu_result (alu_result[i]),
            .rsp_valid  (rsp_valid[i]),
            .rsp_ready  (rsp_ready[i]),
            .rsp_result (rsp_result[i]),
            .rsp_tag    (rsp_tag[i]),
            .busy       (busy[i])
        );

        // Scoreboard: push on acceptance, compare head whenever presented.
        initial forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (rsp_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp dut%0d: got result=%0h tag=%0h expected none",
                                 i, rsp_result[i], rsp_tag[i]);
                    end else begin
                        check($sformatf("rsp dut%0d", i), {19'd0, rsp_result[i], rsp_tag[i]},
                              {19'd0, exp_q[0]});
                        if (rsp_ready[i]) void'(exp_q.pop_front());
                    end
                end
                if (req_valid[i] && req_ready[i])
                    exp_q.push_back({model(req_a[i], req_b[i], req_sel[i]), req_tag[i]});
            end
        end
    end

    // Present a request and hold it until accepted; returns 1ns after the accepting edge.
    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [3:0] tag);
        int n = 0;
        req_a[d]     = a;
        req_b[d]     = b;
        req_sel[d]   = sel;
        req_tag[d]   = tag;
        req_valid[d] = 1'b1;
        @(negedge clk);
        while (!req_ready[d] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready[d]) begin
            total++;
            bad++;
            $display("FAIL issue_timeout dut%0d: got req_ready=0 expected 1 within 200 cycles", d);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input int d);
        check($sformatf("rst req_ready%0d", d), 32'(req_ready[d]), 32'd1);
        check($sformatf("rst alu_a%0d", d), 32'(alu_a[d]), 32'd0);
        check($sformatf("rst alu_b%0d", d), 32'(alu_b[d]), 32'd0);
        check($sformatf("rst alu_sel%0d", d), 32'(alu_sel[d]), 32'd0);
        check($sformatf("rst rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
        check($sformatf("rst rsp_result%0d", d), 32'(rsp_result[d]), 32'd0);
        check($sformatf("rst rsp_tag%0d", d), 32'(rsp_tag[d]), 32'd0);
        check($sformatf("rst busy%0d", d), 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    logic [8:0] b_res [3];
    logic [3:0] b_tag [3];

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_a[d]     = '0;
            req_b[d]     = '0;
            req_sel[d]   = '0;
            req_tag[d]   = '0;
            rsp_ready[d] = 1'b0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);

        // Single ADD, SETTLE=1: response visible after edge k+1.
        cycles(1);
        issue(0, 8'hFF, 8'h00, 4'd0, 4'd1);
        @(negedge clk);
        check("A busy_k", 32'(busy[0]), 32'd1);
        check("A req_ready_k", 32'(req_ready[0]), 32'd0);
        check("A rsp_valid_k", 32'(rsp_valid[0]), 32'd0);
        check("A alu_a", 32'(alu_a[0]), 32'hFF);
        @(negedge clk);
        check("A rsp_valid_k1", 32'(rsp_valid[0]), 32'd1);
        check("A rsp_result", 32'(rsp_result[0]), 32'h0FF);
        check("A rsp_tag", 32'(rsp_tag[0]), 32'd1);
        check("A busy_k1", 32'(busy[0]), 32'd0);
        check("A req_ready_k1", 32'(req_ready[0]), 32'd1);
        cycles(1);
        rsp_ready[0] = 1'b1;
        cycles(1);
        rsp_ready[0] = 1'b0;

        // Three queued ADDs returned in order.
        b_res = '{9'h0FF, 9'h0FF, 9'h1FE};
        b_tag = '{4'd1, 4'd2, 4'd3};
        issue(0, 8'hFF, 8'h00, 4'd0, 4'd1);
        issue(0, 8'hF0, 8'h0F, 4'd0, 4'd2);
        issue(0, 8'hFF, 8'hFF, 4'd0, 4'd3);
        cycles(1);
        rsp_ready[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("B valid%0d", j), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("B result%0d", j), 32'(rsp_result[0]), 32'(b_res[j]));
            check($sformatf("B tag%0d", j), 32'(rsp_tag[0]), 32'(b_tag[j]));
        end
        @(negedge clk);
        check("B empty", 32'(rsp_valid[0]), 32'd0);
        cycles(1);
        rsp_ready[0] = 1'b0;

        // Fill to DEPTH, then one pop reopens the request side.
        for (int j = 0; j < 4; j++) issue(0, 8'(j * 17), 8'(j + 3), 4'(j), 4'(j + 4));
        cycles(1);
        @(negedge clk);
        check("C req_ready_full", 32'(req_ready[0]), 32'd0);
        check("C rsp_valid_full", 32'(rsp_valid[0]), 32'd1);
        cycles(1);
        rsp_ready[0] = 1'b1;
        cycles(1);
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("C req_ready_after_pop", 32'(req_ready[0]), 32'd1);
        cycles(1);
        rsp_ready[0] = 1'b1;
        cycles(6);
        rsp_ready[0] = 1'b0;

        // SETTLE=3: operands held, busy three cycles, request changes ignored.
        issue(1, 8'h12, 8'h34, 4'd1, 4'd5);
        req_valid[1] = 1'b1;
        req_a[1]     = 8'hAA;
        req_b[1]     = 8'hBB;
        req_sel[1]   = 4'd0;
        req_tag[1]   = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("D busy%0d", c), 32'(busy[1]), 32'd1);
            check($sformatf("D alu_a%0d", c), 32'(alu_a[1]), 32'h12);
            check($sformatf("D alu_b%0d", c), 32'(alu_b[1]), 32'h34);
            check($sformatf("D alu_sel%0d", c), 32'(alu_sel[1]), 32'd1);
            check($sformatf("D req_ready%0d", c), 32'(req_ready[1]), 32'd0);
            check($sformatf("D rsp_valid%0d", c), 32'(rsp_valid[1]), 32'd0);
            req_a[1] = 8'(req_a[1] + 8'd1);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("D busy_done", 32'(busy[1]), 32'd0);
        check("D rsp_valid", 32'(rsp_valid[1]), 32'd1);
        check("D rsp_result", 32'(rsp_result[1]), 32'h1DE);
        check("D rsp_tag", 32'(rsp_tag[1]), 32'd5);
        check("D req_ready", 32'(req_ready[1]), 32'd1);

        // Push and pop on the same edge with two entries queued.
        cycles(1);
        issue(1, 8'h01, 8'h02, 4'd0, 4'd6);
        issue(1, 8'h80, 8'h80, 4'd0, 4'd7);
        cycles(2);
        rsp_ready[1] = 1'b1;
        cycles(1);
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        check("E head_tag", 32'(rsp_tag[1]), 32'd6);
        check("E req_ready", 32'(req_ready[1]), 32'd1);
        cycles(1);
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("E tag6", 32'(rsp_tag[1]), 32'd6);
        @(negedge clk);
        check("E tag7", 32'(rsp_tag[1]), 32'd7);
        check("E result7", 32'(rsp_result[1]), 32'h100);
        @(negedge clk);
        check("E count2_drained", 32'(rsp_valid[1]), 32'd0);
        cycles(1);
        rsp_ready[1] = 1'b0;

        // Reset mid-WAIT with two entries queued.
        issue(1, 8'h11, 8'h22, 4'd2, 4'd8);
        issue(1, 8'h33, 8'h44, 4'd3, 4'd9);
        issue(1, 8'h55, 8'h66, 4'd4, 4'd10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals(1);
        check("F dut0 alu_a", 32'(alu_a[0]), 32'd0);
        cycles(2);
        rst = 1'b0;
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("F no_stale%0d", c), 32'(rsp_valid[1]), 32'd0);
        end
        cycles(1);
        issue(1, 8'h07, 8'h09, 4'd0, 4'd2);
        cycles(6);
        rsp_ready[1] = 1'b0;

        // Randomised traffic on both instances with random back-pressure.
        fork
            begin
                for (int c = 0; c < 500; c++) begin
                    @(posedge clk);
                    #1;
                    rsp_ready[0] = 1'($urandom_range(0, 1));
                    rsp_ready[1] = 1'($urandom_range(0, 1));
                end
                rsp_ready[0] = 1'b1;
                rsp_ready[1] = 1'b1;
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    issue(0, 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
                    cycles(int'($urandom_range(0, 2)));
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    issue(1, 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
                    cycles(int'($urandom_range(0, 2)));
                end
            end
        join

        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        cycles(20);
        check("drain dut0", 32'(g_dut[0].exp_q.size()), 32'd0);
        check("drain dut1", 32'(g_dut[1].exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
